// File: rtl/alu_out_pkg_hdl.sv
// Shared opcode encodings, default widths and responder state type for the alu_out responder.
package alu_out_pkg_hdl;

    localparam int unsigned ALU_OUT_OPERAND_WIDTH = 8;
    localparam int unsigned ALU_OUT_RESULT_WIDTH  = 16;
    localparam int unsigned ALU_OUT_STAT_WIDTH    = 16;
    localparam int unsigned ALU_OUT_CNT_WIDTH     = 4;

    typedef enum bit [2:0] {
        no_op  = 3'b000,
        add_op = 3'b001,
        and_op = 3'b010,
        xor_op = 3'b011,
        mul_op = 3'b100,
        rst_op = 3'b111
    } alu_out_op_t;

    typedef enum {IDLE, EXEC, DONE} alu_out_resp_state_t;

endpackage

// File: rtl/alu_out_responder_datapath.sv
// Combinational op/a/b to next-result evaluation; reserved and non-arithmetic ops yield zero.
module alu_out_responder_datapath
    import alu_out_pkg_hdl::*;
#(
    parameter int unsigned OPERAND_WIDTH = ALU_OUT_OPERAND_WIDTH,
    parameter int unsigned RESULT_WIDTH  = 2 * OPERAND_WIDTH
) (
    input  logic [2:0]               op,
    input  logic [OPERAND_WIDTH-1:0] a,
    input  logic [OPERAND_WIDTH-1:0] b,
    output logic [RESULT_WIDTH-1:0]  result_c
);

    // Operands are zero-extended first so carry and full product are kept.
    always_comb begin
        result_c = '0;
        case (op)
            add_op:  result_c = RESULT_WIDTH'(a) + RESULT_WIDTH'(b);
            and_op:  result_c = RESULT_WIDTH'(a & b);
            xor_op:  result_c = RESULT_WIDTH'(a ^ b);
            mul_op:  result_c = RESULT_WIDTH'(a) * RESULT_WIDTH'(b);
            default: result_c = '0;
        endcase
    end

endmodule

// File: rtl/alu_out_responder.sv
// ALU execution block producing one-cycle done pulses on the alu_out interface.
// Optional statistics outputs (op_count, busy) under `ALU_OUT_RESPONDER_STATS_EN.
module alu_out_responder
    import alu_out_pkg_hdl::*;
#(
    parameter int unsigned OPERAND_WIDTH = ALU_OUT_OPERAND_WIDTH,
    parameter int unsigned RESULT_WIDTH  = 2 * OPERAND_WIDTH,
    parameter int unsigned MUL_LATENCY   = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid,
    output logic                     ready,
    input  logic [2:0]               op,
    input  logic [OPERAND_WIDTH-1:0] a,
    input  logic [OPERAND_WIDTH-1:0] b,
    output logic                     done,
    output logic [RESULT_WIDTH-1:0]  result
`ifdef ALU_OUT_RESPONDER_STATS_EN
    ,
    output logic [ALU_OUT_STAT_WIDTH-1:0] op_count,
    output logic                          busy
`endif
);

    localparam int unsigned CNT_W = ALU_OUT_CNT_WIDTH;

    alu_out_resp_state_t       state;
    logic [CNT_W-1:0]          cnt;
    logic [2:0]                op_q;
    logic [OPERAND_WIDTH-1:0]  a_q;
    logic [OPERAND_WIDTH-1:0]  b_q;
    logic [RESULT_WIDTH-1:0]   next_result_c;

    alu_out_responder_datapath #(
        .OPERAND_WIDTH (OPERAND_WIDTH),
        .RESULT_WIDTH  (RESULT_WIDTH)
    ) u_datapath (
        .op       (op_q),
        .a        (a_q),
        .b        (b_q),
        .result_c (next_result_c)
    );

    // FSM, latency counter and all output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            ready  <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            cnt    <= '0;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
`ifdef ALU_OUT_RESPONDER_STATS_EN
            op_count <= '0;
            busy     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    ready <= 1'b1;
                    if (valid && ready) begin
                        op_q <= op;
                        a_q  <= a;
                        b_q  <= b;
                        case (op)
                            add_op, and_op, xor_op, mul_op: begin
                                state <= EXEC;
                                ready <= 1'b0;
                                cnt   <= (op == mul_op) ? CNT_W'(MUL_LATENCY - 1) : '0;
`ifdef ALU_OUT_RESPONDER_STATS_EN
                                busy  <= 1'b1;
`endif
                            end
                            rst_op: begin
                                result <= '0;
`ifdef ALU_OUT_RESPONDER_STATS_EN
                                op_count <= '0;
`endif
                            end
                            default: ;
                        endcase
                    end
                end
                EXEC: begin
                    ready <= 1'b0;
                    if (cnt == '0) begin
                        result <= next_result_c;
                        done   <= 1'b1;
                        state  <= DONE;
`ifdef ALU_OUT_RESPONDER_STATS_EN
                        if (op_count != '1) begin
                            op_count <= op_count + ALU_OUT_STAT_WIDTH'(1);
                        end
`endif
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DONE: begin
                    // One-cycle bubble before the next request can be taken.
                    state <= IDLE;
                    ready <= 1'b1;
`ifdef ALU_OUT_RESPONDER_STATS_EN
                    busy  <= 1'b0;
`endif
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
